// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: four registered quarter-phases with phase strobes.
// Optional clock-stretch freeze of the high phase: define I2C_CLK_STRETCH_EN.
module i2c_scl_gen #(
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 249,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             scl_i,
    output logic             scl_o,
    output logic             fall_stb,
    output logic             chg_stb,
    output logic             rise_stb,
    output logic             smp_stb,
    output logic [1:0]       phase_o,
    output logic             stretch_o
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] STR_MIN = DIV_W'(SYNC_STAGES + 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       ph_q, ph_d;
    logic             scl_q, scl_d;
    logic [3:0]       stb_q, stb_d;
    logic             str_q, str_d;
    logic [DIV_W-1:0] div_eff;
    logic             stall;

    assign div_eff = (div_i == '0) ? DEF_DIV : div_i;

`ifdef I2C_CLK_STRETCH_EN
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], scl_i};
    end

    // Wait out the synchroniser lag so our own low phase is not seen as a stretch.
    assign stall = (state_q == RUN) && (ph_q == 2'd2) &&
                   (cnt_q >= STR_MIN) && !sync_q[SYNC_STAGES-1];
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        ph_d    = ph_q;
        stb_d   = 4'b0000;
        str_d   = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            ph_d    = 2'd0;
        end else if (state_q == IDLE) begin
            state_d = RUN;
            cnt_d   = '0;
            ph_d    = 2'd0;
            div_d   = div_eff;
            stb_d   = 4'b0001;
        end else if (stall) begin
            str_d = 1'b1;
        end else if (cnt_q == div_q) begin
            cnt_d = '0;
            ph_d  = ph_q + 2'd1;
            stb_d = 4'b0001 << ph_d;
            if (ph_q == 2'd3) div_d = div_eff;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        scl_d = (state_d == IDLE) | ph_d[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DEF_DIV;
            ph_q    <= 2'd0;
            scl_q   <= 1'b1;
            stb_q   <= 4'b0000;
            str_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            scl_q   <= scl_d;
            stb_q   <= stb_d;
            str_q   <= str_d;
        end
    end

    assign scl_o     = scl_q;
    assign fall_stb  = stb_q[0];
    assign chg_stb   = stb_q[1];
    assign rise_stb  = stb_q[2];
    assign smp_stb   = stb_q[3];
    assign phase_o   = ph_q;
    assign stretch_o = str_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen: period-position reference model plus directed timing checks.
// Honours I2C_CLK_STRETCH_EN the same way as the design.
module tb_i2c_scl_gen;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_i = 1'b0;
    logic [15:0] div_i = '0;
    logic        scl_i = 1'b1;
    logic        scl_o, fall_stb, chg_stb, rise_stb, smp_stb, stretch_o;
    logic [1:0]  phase_o;
    logic        hold = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    i2c_scl_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .div_i    (div_i),
        .scl_i    (scl_i),
        .scl_o    (scl_o),
        .fall_stb (fall_stb),
        .chg_stb  (chg_stb),
        .rise_stb (rise_stb),
        .smp_stb  (smp_stb),
        .phase_o  (phase_o),
        .stretch_o(stretch_o)
    );

    always #5 clk = ~clk;

    logic [7:0] vec;
    assign vec = {scl_o, phase_o, smp_stb, rise_stb, chg_stb, fall_stb, stretch_o};

    // Model: position within the period in unfrozen cycles.
    bit   m_run;
    int   m_pos, m_q;
    bit   m_scl;
    logic [7:0] m_exp;
    bit   hist[$];

    function automatic int qlen(input int d);
        return (d == 0) ? 250 : d + 1;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_pos = 0;
        m_q   = 250;
        m_scl = 1;
        m_exp = 8'h80;
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(1'b1);
    endtask

    task automatic model_step(input bit en, input int d, input bit sin);
        bit synced, adv, str;
        int ph;
        logic [3:0] stb;
        synced = hist[S-1];
        hist.push_front(sin);
        void'(hist.pop_back());
        adv = 0;
        str = 0;
        if (!en) begin
            m_run = 0;
            m_pos = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_pos = 0;
            m_q   = qlen(d);
            adv   = 1;
        end else begin
`ifdef I2C_CLK_STRETCH_EN
            if (m_pos / m_q == 2 && m_pos % m_q >= S + 1 && !synced) str = 1;
`endif
            if (!str) begin
                m_pos++;
                if (m_pos == 4 * m_q) begin
                    m_pos = 0;
                    m_q   = qlen(d);
                end
                adv = 1;
            end
        end
        ph    = m_run ? m_pos / m_q : 0;
        m_scl = !m_run || ph >= 2;
        stb   = (adv && m_pos % m_q == 0) ? (4'b0001 << ph) : 4'b0000;
        m_exp = {m_scl, 2'(ph), stb, str};
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit sin;
        sin   = m_scl & ~hold;
        scl_i = sin;
        model_step(en_i, int'(div_i), sin);
        @(posedge clk);
        #1;
        chk("cycle", int'(vec), int'(m_exp));
    endtask

    task automatic wait_bit(input int b, input string nm, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!vec[b] && n < limit);
        if (!vec[b]) chk({nm, "_timeout"}, 0, 1);
    endtask

    int n, smp_at, rel_at;
    bit st50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vec", int'(vec), 8'h80);
        rst = 1'b1;

        en_i  = 1'b1;
        div_i = 16'd0;
        tick();
        chk("first_fall", int'(vec), 8'h02);
        wait_bit(2, "dflt_chg", 2000, n);
        chk("dflt_chg_gap", n, 250);
        wait_bit(3, "dflt_rise", 2000, n);
        chk("dflt_rise_gap", n, 250);
        wait_bit(4, "dflt_smp", 2000, n);
        chk("dflt_smp_gap", n, 250);
        wait_bit(1, "dflt_fall", 2000, n);
        chk("dflt_period_end", n, 250);

        en_i = 1'b0;
        tick();
        div_i = 16'd3;
        en_i  = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("div3_phase", int'(phase_o), ((k + 1) / 4) % 4);
        end

        en_i = 1'b0;
        tick();
        div_i = 16'd1;
        en_i  = 1'b1;
        tick();
        wait_bit(2, "div1_chg", 50, n);
        chk("div1_chg_gap", n, 2);
        wait_bit(3, "div1_rise", 50, n);
        chk("div1_rise_gap", n, 2);

        en_i = 1'b0;
        tick();
        div_i = 16'd3;
        en_i  = 1'b1;
        tick();
        repeat (5) tick();
        div_i = 16'd7;
        wait_bit(1, "chgdiv_fall", 100, n);
        chk("chgdiv_old_period", n, 11);
        wait_bit(2, "chgdiv_chg", 100, n);
        chk("chgdiv_new_quarter", n, 8);

        en_i = 1'b0;
        tick();
        div_i = 16'd3;
        en_i  = 1'b1;
        tick();
        wait_bit(3, "exit_rise", 100, n);
        repeat (3) tick();
        en_i = 1'b0;
        tick();
        chk("exit_idle", int'(vec), 8'h80);
        en_i = 1'b1;
        tick();
        chk("reenter_fall", int'(vec), 8'h02);

        en_i = 1'b0;
        tick();
        div_i = 16'd9;
        en_i  = 1'b1;
        tick();
        wait_bit(3, "str_rise", 100, n);
        smp_at = 0;
        rel_at = 0;
        st50   = 0;
        for (int i = 1; i <= 60; i++) begin
            hold = (i <= 50);
            tick();
            if (smp_stb && smp_at == 0) smp_at = i;
            if (i == 50) st50 = stretch_o;
            if (i > 50 && !stretch_o && rel_at == 0) rel_at = i;
        end
        hold = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
        chk("str_smp_delay", smp_at, 59);
        chk("str_active", int'(st50), 1);
        chk("str_release", rel_at - 50, S + 1);
`else
        chk("str_smp_delay", smp_at, 10);
        chk("str_active", int'(st50), 0);
        chk("str_release", rel_at - 50, 1);
`endif

        en_i  = 1'b1;
        div_i = 16'd2;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 299) == 0) en_i = ~en_i;
            if ($urandom_range(0, 19) == 0)
                div_i = ($urandom_range(0, 49) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            tick();
        end
        hold = 1'b0;

        en_i = 1'b0;
        tick();
        div_i = 16'd3;
        en_i  = 1'b1;
        tick();
        repeat (13) tick();
        chk("pre_reset_phase", int'(phase_o), 3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", int'(vec), 8'h80);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        tick();
        chk("post_reset_fall", int'(vec), 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_scl_gen.md
# i2c_scl_gen

Programmable I2C bus-clock generator. It divides the 100 MHz system clock into four equal quarter-phases per SCL period and drives the SCL level. It issues single-cycle strobes at the four phase points the I2C byte engine needs: fall, data-change, rise and sample. The divisor is a run-time input, latched once per period. Optional clock-stretch detection holds the high phase while a slave keeps SCL low.

## Interface
- DIV_W, 16, width of the divisor input and the quarter counter
- DIV_DEFAULT, 249, divisor used while `div_i` is 0 (249 gives 100 kHz SCL at 100 MHz)
- SYNC_STAGES, 2, synchroniser depth on `scl_i` (legal range 2..3)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en_i  in  1  run enable; low forces idle
- div_i  in  DIV_W  quarter length minus 1 (quarter = div+1 clk cycles); 0 selects DIV_DEFAULT
- scl_i  in  1  sensed SCL pin level (asynchronous)
- scl_o  out  1  SCL drive level (1 = release/high)
- fall_stb  out  1  1-cycle pulse when SCL is driven low (start of phase 0)
- chg_stb  out  1  1-cycle pulse at mid-low (start of phase 1); SDA may change
- rise_stb  out  1  1-cycle pulse when SCL is released (start of phase 2)
- smp_stb  out  1  1-cycle pulse at mid-high (start of phase 3); sample SDA
- phase_o  out  2  current quarter-phase 0..3
- stretch_o  out  1  high while the high phase is frozen by a stretching slave

## Operation
- Reset values: scl_o=1, all strobes 0, phase_o=0, stretch_o=0, quarter counter 0, latched divisor = DIV_DEFAULT.
- Idle (en_i=0): the counter and phase are held at 0, scl_o=1, and no strobes are issued.
- Run: the counter increments every clk cycle. When it equals the latched divisor, it returns to 0 and phase_o advances (3 wraps to 0). The strobe for the new phase is asserted on the same edge.
- scl_o levels: 0 in phases 0 and 1; 1 in phases 2 and 3. All outputs are registered.
- Divisor latch: `div_i` is captured only on the phase 3→0 transition and on entry to run. The active divisor is `div_i` when non-zero, otherwise DIV_DEFAULT. Mid-period changes to `div_i` have no effect until the next fall.
- Entry into run: the divisor is latched, and phase 0 starts with scl_o=0 and fall_stb on the first edge after en_i is sampled high.
- Exit from run: when en_i drops at any point, the next edge returns to the idle state. No strobe is issued on that edge, even if the counter would have matched.
- Stretch (when compiled in): the block watches the synchronised `scl_i` during phase 2.
  - If it reads 0 once SYNC_STAGES+1 cycles have elapsed since rise_stb, the counter freezes and stretch_o=1.
  - When it reads 1 again, the freeze ends: stretch_o=0, and counting resumes from the frozen value.
  - The sample point therefore moves later by the stretch duration.
  - `scl_i` is ignored in phases 0, 1 and 3.
- Counter arithmetic: the counter is DIV_W bits unsigned and never exceeds the latched divisor.

## Timing
- Quarter = div+1 cycles. Unstretched SCL period = 4·(div+1) cycles. With the default divisor: 250 / 1000 cycles.
- First fall_stb: 1 cycle after en_i is sampled high. chg_stb follows div+1 cycles later, then rise_stb, then smp_stb, each div+1 cycles apart.
- Strobes are mutually exclusive, last exactly one cycle, and coincide with the scl_o transition edge where one exists.
- Stretch release latency: scl_i rising → stretch_o low in SYNC_STAGES+1 cycles.
- Minimum divisor is 1 (quarter = 2 cycles). div_i=0 never means a 1-cycle quarter.
- Reset asserted mid-run: all outputs take their reset values asynchronously. On release, the block re-enters run only when en_i is sampled high.

## Configuration
- I2C_CLK_STRETCH_EN
  - Defined: the synchroniser, the stretch freeze and stretch_o are implemented.
  - Undefined: scl_i is unused, stretch_o is tied to 0, and phase 2 always lasts exactly div+1 cycles.

## Test plan
- Reset, then en_i=1 with div_i=0: fall_stb 1 cycle after en_i is sampled high. chg/rise/smp strobes follow at +250, +500 and +750 cycles. The period is 1000 cycles with the scl_o duty at 50%.
- div_i=3, held enabled: strobes every 4 cycles and phase_o cycling 0,1,2,3. div_i=1: quarter = 2 cycles.
- Change div_i from 3 to 7 while in phase 1: the current period completes with 4-cycle quarters. The quarters after the next fall_stb are 8 cycles.
- en_i dropped in phase 2 at the matching count: no smp_stb, and scl_o=1, phase_o=0 on the next edge. Re-enable: fall_stb after 1 cycle.
- Stretch (macro defined, div_i=9): drive scl_i low from rise_stb for 50 cycles. Required: stretch_o high, counter frozen, smp_stb delayed by ~50 cycles, stretch_o low SYNC_STAGES+1 cycles after release. Same stimulus with the macro undefined: timing unchanged.
- Assert rst mid-phase 3: scl_o=1, strobes 0 and phase_o=0 immediately, without a clock edge.
